// File: rtl/col_parity_check_pkg.sv
// ---------------------------------------------------------------------------
// col_parity_check_pkg
//   Constants and the controller state encoding shared by the column-parity
//   checker and its controller.
//   LINE_W  : bits per slice (5x5 matrix, bit index 5*y+x)
//   N_LINES : slices per matrix, i.e. addresses walked in one pass
//   ADDR_W  : width of the address counter (one bit wider than the address
//             range so the post-pass value N_LINES is representable)
//   PAR_W   : number of columns = number of parity/syndrome bits
// ---------------------------------------------------------------------------
package col_parity_check_pkg;

  localparam int LINE_W  = 25;
  localparam int N_LINES = 64;
  localparam int ADDR_W  = 7;
  localparam int PAR_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : col_parity_check_pkg

// File: rtl/colcheck_controller.sv
// ---------------------------------------------------------------------------
// colcheck_controller
//   Sequencer for one column-parity check pass:
//   IDLE -> READ (one address per cycle) -> DRAIN (2 cycles) -> DONE -> IDLE.
//
//   Ports
//     clk       in  : clock, rising edge
//     rst       in  : asynchronous, active-low reset
//     start     in  : begin a pass (only looked at in IDLE)
//     cnt_carry in  : address counter is on the last address this cycle
//     cnt_en    out : advance the address counter
//     cnt_rst   out : clear the address counter (pass acceptance edge)
//     stat_clr  out : clear error statistics (pass acceptance edge)
//     chk_en    out : line_in/parity_in carry valid slice data this cycle
//     done      out : end-of-pass pulse (DONE state)
//     busy      out : pass in progress (READ or DRAIN)
// ---------------------------------------------------------------------------
module colcheck_controller
  import col_parity_check_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cnt_carry,
  output logic cnt_en,
  output logic cnt_rst,
  output logic stat_clr,
  output logic chk_en,
  output logic done,
  output logic busy
);

  state_e state_q, state_d;
  logic   drain_q, drain_d;   // 0 = first DRAIN cycle, 1 = second
  logic   chk_q;              // address issued last cycle -> data valid now

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      drain_q <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      // The slice memory answers one cycle after the address, so the
      // data-valid window is the address window delayed by one cycle.
      chk_q   <= cnt_en;
    end
  end

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    cnt_en   = 1'b0;
    cnt_rst  = 1'b0;
    stat_clr = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          cnt_rst  = 1'b1;
          stat_clr = 1'b1;
        end
      end
      ST_READ: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (cnt_carry) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Two cycles: lets the last returned slice be checked and its
        // registered syndrome become visible before DONE.
        busy = 1'b1;
        if (drain_q) begin
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign chk_en = chk_q;

endmodule : colcheck_controller

// File: rtl/col_parity_check.sv
// ---------------------------------------------------------------------------
// col_parity_check
//   Walks all slices of a 5x5-bit-slice matrix, recomputes the column parity
//   of every slice and compares it with the stored parity, reporting a
//   per-slice syndrome plus pass statistics.
//
//   Ports
//     clk            in  : clock, rising edge
//     rst            in  : asynchronous, active-low reset
//     start          in  : begin a pass (ignored unless idle)
//     cnt_value      out : read address for slice and parity memories
//     line_in        in  : slice data, valid the cycle after its address
//     parity_in      in  : stored column parity, same timing as line_in
//     busy           out : pass in progress
//     syndrome_valid out : one-cycle strobe per checked slice
//     syndrome       out : recomputed parity XOR parity_in (holds when idle)
//     err_flag       out : any nonzero syndrome seen in this pass (sticky)
//     err_count      out : number of slices with nonzero syndrome
//     first_err_addr out : address of the first failing slice
//     donee          out : one-cycle end-of-pass pulse
// ---------------------------------------------------------------------------
module col_parity_check
  import col_parity_check_pkg::PAR_W;
#(
  parameter int LINE_W  = col_parity_check_pkg::LINE_W,
  parameter int N_LINES = col_parity_check_pkg::N_LINES,
  parameter int ADDR_W  = col_parity_check_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] cnt_value,
  input  logic [LINE_W-1:0] line_in,
  input  logic [PAR_W-1:0]  parity_in,
  output logic              busy,
  output logic              syndrome_valid,
  output logic [PAR_W-1:0]  syndrome,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_count,
  output logic [ADDR_W-2:0] first_err_addr,
  output logic              donee
);

  // Controller handshake
  logic cnt_en;
  logic cnt_rst;
  logic stat_clr;
  logic chk_en;
  logic done;
  logic ctrl_busy;
  logic cnt_carry;

  // Address counter and the address of the slice currently on line_in
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-2:0] addr_pipe_q, addr_pipe_d;

  // Parity reduction
  logic [PAR_W-1:0] col_par;
  logic [PAR_W-1:0] syn_calc;
  logic             syn_nonzero;

  // Result registers
  logic [PAR_W-1:0]  syndrome_q, syndrome_d;
  logic              syn_valid_q, syn_valid_d;
  logic              err_flag_q, err_flag_d;
  logic [ADDR_W-1:0] err_count_q, err_count_d;
  logic [ADDR_W-2:0] first_err_q, first_err_d;

  colcheck_controller u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cnt_carry (cnt_carry),
    .cnt_en    (cnt_en),
    .cnt_rst   (cnt_rst),
    .stat_clr  (stat_clr),
    .chk_en    (chk_en),
    .done      (done),
    .busy      (ctrl_busy)
  );

  // -------------------------------------------------------------------------
  // Address counter: runs 0..N_LINES-1 in READ, steps once more to N_LINES
  // on the carry edge and then holds there until the next accepted start.
  // -------------------------------------------------------------------------
  assign cnt_carry = cnt_en && (cnt_q == ADDR_W'(N_LINES - 1));

  always_comb begin
    cnt_d       = cnt_q;
    addr_pipe_d = addr_pipe_q;
    if (cnt_rst) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d       = cnt_q + ADDR_W'(1);
      addr_pipe_d = cnt_q[ADDR_W-2:0];
    end
  end

  // -------------------------------------------------------------------------
  // Column parity: column x collects bits 5*y+x for every row y.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_col
    logic [PAR_W-1:0] column;
    for (genvar gj = 0; gj < PAR_W; gj++) begin : g_row
      assign column[gj] = line_in[PAR_W*gj + gi];
    end
    assign col_par[gi] = ^column;
  end

  assign syn_calc    = col_par ^ parity_in;
  assign syn_nonzero = |syn_calc;

  // -------------------------------------------------------------------------
  // Syndrome and pass statistics
  // -------------------------------------------------------------------------
  always_comb begin
    syndrome_d  = syndrome_q;
    syn_valid_d = chk_en;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;

    if (chk_en) begin
      syndrome_d = syn_calc;
    end

    if (stat_clr) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
      first_err_d = '0;
    end else if (chk_en && syn_nonzero) begin
      // Statistics update on the same edge that registers the syndrome, so
      // err_count already includes a failing slice while its strobe is high.
      err_count_d = err_count_q + ADDR_W'(1);
      if (!err_flag_q) begin
        first_err_d = addr_pipe_q;
      end
      err_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      addr_pipe_q <= '0;
      syndrome_q  <= '0;
      syn_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      addr_pipe_q <= addr_pipe_d;
      syndrome_q  <= syndrome_d;
      syn_valid_q <= syn_valid_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign cnt_value      = cnt_q;
  assign busy           = ctrl_busy;
  assign donee          = done;
  assign syndrome_valid = syn_valid_q;
  assign syndrome       = syndrome_q;
  assign err_flag       = err_flag_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule : col_parity_check
